add_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs a wide addition by time-sharing one 4-bit adder slice. Operands are split into nibbles and fed least-significant first, with the carry held in a register between cycles. The block sits between a requesting controller (start/done handshake) and a single instance of the team's 4-bit adder. It trades latency for area in the arithmetic datapath.

---
 rtl/add_seq_ctrl_pkg.sv | 12 +
 rtl/add_seq_ctrl_adder4bits.sv | 11 +
 rtl/add_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the add_seq_ctrl sequencer: FSM state encodings and slice width.
package add_seq_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_seq_ctrl_adder4bits.sv
// 4-bit adder slice with carry in; s[4] is the carry out.
module adder4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [4:0] s
);

  assign s = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide adder built by time-sharing one adder4bits slice, least-significant nibble first.
// Optional subtract mode is enabled by defining ADD_SEQ_SUB_EN.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
`ifdef ADD_SEQ_SUB_EN
  input  logic                          sub,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e                              state_r, state_nxt_s;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    op_a_r, op_b_r, sum_r;
  logic [IDX_W-1:0]                    idx_r;
  logic                                carry_r, cout_r;
  logic                                accept_s, step_s, last_s;
  logic [NIBBLE_W-1:0]                 b_nib_s;
  logic                                carry_init_s;
  logic [NIBBLE_W:0]                   slice_s;

`ifdef ADD_SEQ_SUB_EN
  logic sub_r;

  assign b_nib_s      = op_b_r[idx_r] ^ {NIBBLE_W{sub_r}};
  assign carry_init_s = sub;
`else
  assign b_nib_s      = op_b_r[idx_r];
  assign carry_init_s = 1'b0;
`endif

  adder4bits u_slice (
    .a  (op_a_r[idx_r]),
    .b  (b_nib_s),
    .ci (carry_r),
    .s  (slice_s)
  );

  assign last_s = (idx_r == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus accept/step strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture, nibble stepping, carry chain and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r  <= '0;
      op_b_r  <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      op_a_r  <= a;
      op_b_r  <= b;
      idx_r   <= '0;
      carry_r <= carry_init_s;
`ifdef ADD_SEQ_SUB_EN
      sub_r   <= sub;
`endif
    end else if (step_s) begin
      sum_r[idx_r] <= slice_s[NIBBLE_W-1:0];
      carry_r      <= slice_s[NIBBLE_W];
      // idx parks on the top nibble rather than wrapping.
      if (last_s) begin
        cout_r <= slice_s[NIBBLE_W];
      end else begin
        idx_r <= idx_r + IDX_W'(1'b1);
      end
    end
  end

  assign busy = (state_r == ST_RUN);
  assign done = (state_r == ST_DONE);
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: directed scenarios plus randomized operands against an arithmetic model.
module tb_add_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         sub   = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef ADD_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkw(string tag, logic [W:0] obs, logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, sum} from plain integer arithmetic on the operand values.
  function automatic logic [W:0] model(logic [W-1:0] x, logic [W-1:0] y, logic s);
    longint xa  = longint'(x);
    longint yb  = longint'(y);
    longint m   = longint'(1) << W;
    longint r;
    logic   c;
    if (s) begin
      r = (xa - yb + m) % m;
      c = (xa >= yb);
    end else begin
      r = (xa + yb) % m;
      c = ((xa + yb) >= m);
    end
    return {c, W'(r)};
  endfunction

  task automatic launch(logic [W-1:0] x, logic [W-1:0] y, logic s);
    start = 1'b1;
    a     = x;
    b     = y;
    sub   = s;
  endtask

  // Start is already driven in cycle 0; walks cycles 1..NIB+1 and ends in the done cycle.
  task automatic run_check(string tag, logic [W:0] exp, int poke);
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    for (int c = 1; c <= NIB + 1; c++) begin
      check1({tag, "_busy"}, busy, (c <= NIB));
      check1({tag, "_done"}, done, (c == NIB + 1));
      if (c == poke) begin
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h1111;
      end else begin
        start = 1'b0;
      end
      if (c <= NIB) tick();
    end
    checkw({tag, "_result"}, {cout, sum}, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    // Reset state
    tick();
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    checkw("rst_result", {cout, sum}, {1'b0, 16'h0000});
    rst_n = 1'b1;
    tick();

    // Basic add and hold in following idle cycles
    launch(16'h1234, 16'h4321, 1'b0);
    run_check("basic", {1'b0, 16'h5555}, 0);
    tick();
    check1("basic_idle_done", done, 1'b0);
    check1("basic_idle_busy", busy, 1'b0);
    tick();
    checkw("basic_hold", {cout, sum}, {1'b0, 16'h5555});

    // Full carry ripple
    launch(16'hFFFF, 16'h0001, 1'b0);
    run_check("ripple", {1'b1, 16'h0000}, 0);
    tick();

    // Start while busy is ignored
    launch(16'h00FF, 16'h0001, 1'b0);
    run_check("busy_start", {1'b0, 16'h0100}, 2);
    for (int i = 0; i < NIB + 2; i++) begin
      tick();
      check1("busy_start_single_done", done, 1'b0);
    end

    // Back-to-back: new start held in the done cycle
    launch(16'h0001, 16'h0002, 1'b0);
    run_check("b2b_first", {1'b0, 16'h0003}, 0);
    launch(16'h8000, 16'h8000, 1'b0);
    run_check("b2b_second", {1'b1, 16'h0000}, 0);
    tick();

    // Reset in cycle 3 of a run
    launch(16'h1357, 16'h2468, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_done", done, 1'b0);
    checkw("midrst_result", {cout, sum}, {1'b0, 16'h0000});
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NIB + 2; i++) begin
      tick();
      check1("midrst_no_done", done, 1'b0);
    end
    launch(16'h1357, 16'h2468, 1'b0);
    run_check("after_rst", model(16'h1357, 16'h2468, 1'b0), 0);
    tick();

`ifdef ADD_SEQ_SUB_EN
    launch(16'h0005, 16'h0007, 1'b1);
    run_check("sub_borrow", {1'b0, 16'hFFFE}, 0);
    tick();
    launch(16'h0007, 16'h0005, 1'b1);
    run_check("sub_noborrow", {1'b1, 16'h0002}, 0);
    tick();
`endif

    // Randomized operands, some back-to-back
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef ADD_SEQ_SUB_EN
      rs = 1'($urandom_range(1, 0));
`else
      rs = 1'b0;
`endif
      launch(ra, rb, rs);
      run_check("random", model(ra, rb, rs), 0);
      if ($urandom_range(1, 0) == 0) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
